dsp_rx_format: RTL and testbench



---
 rtl/dsp_rx_format.sv | 229 ++++++++++++++++++++++
 tb/tb_dsp_rx_format.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_rx_format.sv
// RX DSP output stage: per-channel gain, round-half-away-from-zero, saturation,
// optional I/Q swap or half-width pair packing, and a first-word-fall-through output FIFO.
module dsp_rx_format #(
  parameter int BASE      = 160,
  parameter int WIDTH_IN  = 24,
  parameter int WIDTH_OUT = 16,
  parameter int FIFO_AW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  input  logic                   run,
  input  logic [WIDTH_IN-1:0]    in_i,
  input  logic [WIDTH_IN-1:0]    in_q,
  input  logic                   in_stb,
  output logic [2*WIDTH_OUT-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic [31:0]            sample_count
);

  localparam int PW     = WIDTH_IN + 17;
  localparam int HW     = WIDTH_OUT / 2;
  localparam int S_FULL = WIDTH_IN - WIDTH_OUT + 14;
  localparam int S_HALF = S_FULL + HW;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int OW     = 2 * WIDTH_OUT;
  localparam int CW     = FIFO_AW + 1;

  localparam logic [7:0] ADDR_SCALE = 8'(BASE);
  localparam logic [7:0] ADDR_MODE  = 8'(BASE + 1);
  localparam logic [7:0] ADDR_CLR   = 8'(BASE + 2);

  // Symmetric rounding: negative products get a bias one smaller so ties move away from zero.
  function automatic logic [WIDTH_OUT-1:0] rnd_sat(input logic signed [PW-1:0] p, input logic half);
    logic signed [PW:0] one, x, bias, sum, sh, lim_hi, lim_lo;
    one = {{PW{1'b0}}, 1'b1};
    x   = {p[PW-1], p};
    if (half) begin
      bias   = one <<< (S_HALF - 1);
      lim_hi = (one <<< (HW - 1)) - one;
      lim_lo = -(one <<< (HW - 1));
    end else begin
      bias   = one <<< (S_FULL - 1);
      lim_hi = (one <<< (WIDTH_OUT - 1)) - one;
      lim_lo = -(one <<< (WIDTH_OUT - 1));
    end
    if (p[PW-1]) bias = bias - one;
    sum = x + bias;
    sh  = half ? (sum >>> S_HALF) : (sum >>> S_FULL);
    if (sh > lim_hi)      sh = lim_hi;
    else if (sh < lim_lo) sh = lim_lo;
    return sh[WIDTH_OUT-1:0];
  endfunction

  // Settings registers
  logic [15:0] scale_i_reg, scale_q_reg;
  logic        swap_reg, half_reg;
  logic        ovf_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_i_reg <= 16'd16384;
      scale_q_reg <= 16'd16384;
      swap_reg    <= 1'b0;
      half_reg    <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == ADDR_SCALE) begin
        scale_i_reg <= set_data[31:16];
        scale_q_reg <= set_data[15:0];
      end
      if (set_addr == ADDR_MODE) begin
        swap_reg <= set_data[0];
        half_reg <= set_data[1];
      end
    end
  end

  assign ovf_clr = set_stb && (set_addr == ADDR_CLR);

  // Pipeline valids
  logic s1_valid_reg, s2_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= run && in_stb;
      s2_valid_reg <= run && s1_valid_reg;
    end
  end

  // Lane 0 carries the output I slot, lane 1 the output Q slot.
  logic [WIDTH_IN-1:0]  lane_in    [2];
  logic [15:0]          lane_scale [2];
  logic [WIDTH_OUT-1:0] rnd_word   [2];

  assign lane_in[0]    = swap_reg ? in_q : in_i;
  assign lane_in[1]    = swap_reg ? in_i : in_q;
  assign lane_scale[0] = scale_i_reg;
  assign lane_scale[1] = scale_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [PW-1:0]  samp_ext, gain_ext;
      logic signed [PW-1:0]  prod_reg;
      logic [WIDTH_OUT-1:0]  rnd_reg;

      assign samp_ext = PW'(signed'(lane_in[gi]));
      assign gain_ext = PW'(signed'({1'b0, lane_scale[gi]}));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_reg <= '0;
          rnd_reg  <= '0;
        end else begin
          if (run && in_stb) prod_reg <= samp_ext * gain_ext;
          if (s1_valid_reg)  rnd_reg  <= rnd_sat(prod_reg, half_reg);
        end
      end

      assign rnd_word[gi] = rnd_reg;
    end
  endgenerate

  // Stage 3: word assembly and pair packing
  logic                 phase_reg;
  logic [WIDTH_OUT-1:0] hold_reg;
  logic                 push_req;
  logic [OW-1:0]        push_word;

  always_comb begin
    push_req  = 1'b0;
    push_word = {rnd_word[0], rnd_word[1]};
    if (run && s2_valid_reg) begin
      if (!half_reg) begin
        push_req = 1'b1;
      end else if (phase_reg) begin
        push_req  = 1'b1;
        push_word = {hold_reg, rnd_word[0][HW-1:0], rnd_word[1][HW-1:0]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= 1'b0;
      hold_reg  <= '0;
    end else if (!run) begin
      phase_reg <= 1'b0;
    end else if (s2_valid_reg && half_reg) begin
      phase_reg <= ~phase_reg;
      if (!phase_reg) hold_reg <= {rnd_word[0][HW-1:0], rnd_word[1][HW-1:0]};
    end
  end

  // Output FIFO. count_reg includes the word presented on out_data; the head register
  // reads the array's previous contents, so a fresh word shows up one cycle after its write.
  logic [OW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]      count_reg, avail;
  logic [OW-1:0]      out_data_reg;
  logic               out_valid_reg;
  logic               pop, full, push_ok, drop;

  always_comb begin
    pop         = out_valid_reg && out_ready;
    full        = (count_reg == CW'(DEPTH));
    push_ok     = push_req && (!full || pop);
    drop        = push_req && full && !pop;
    avail       = count_reg - CW'(pop);
    rd_ptr_next = rd_ptr_reg + FIFO_AW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (!run) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= avail + CW'(push_ok);
      out_valid_reg <= (avail != '0);
      if (avail != '0) out_data_reg <= mem[rd_ptr_next];
    end
  end

  // Status: sticky overflow and accepted-sample counter
  logic        overflow_reg;
  logic        run_d_reg;
  logic [31:0] sample_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg     <= 1'b0;
      run_d_reg        <= 1'b0;
      sample_count_reg <= '0;
    end else begin
      run_d_reg <= run;
      if (drop)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      if (run && !run_d_reg)  sample_count_reg <= in_stb ? 32'd1 : 32'd0;
      else if (run && in_stb) sample_count_reg <= sample_count_reg + 32'd1;
    end
  end

  assign out_data     = out_data_reg;
  assign out_valid    = out_valid_reg;
  assign overflow     = overflow_reg;
  assign sample_count = sample_count_reg;

endmodule

// File: tb/tb_dsp_rx_format.sv
// Directed bench for dsp_rx_format at WIDTH_IN=24, WIDTH_OUT=16 with hand-computed words.
module tb_dsp_rx_format;
  localparam int BASE = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        run;
  logic [23:0] in_i, in_q;
  logic        in_stb;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic [31:0] sample_count;

  int n_checks = 0;
  int n_pass   = 0;

  dsp_rx_format #(.BASE(BASE), .WIDTH_IN(24), .WIDTH_OUT(16), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .run(run), .in_i(in_i), .in_q(in_q), .in_stb(in_stb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // All tasks start and end 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int off, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = 8'(BASE + off);
    set_data = data;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic strobe(input logic [23:0] i, input logic [23:0] q);
    in_i   = i;
    in_q   = q;
    in_stb = 1'b1;
    tick();
    in_stb = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic restart();
    run = 1'b0;
    tick();
    tick();
    run = 1'b1;
    tick();
  endtask

  // One sample into an empty FIFO: out_valid must rise on the 3rd edge after the strobe edge.
  task automatic single(input string tag, input logic [23:0] i, input logic [23:0] q,
                        input logic [31:0] exp);
    strobe(i, q);
    tick();
    check({tag, "_lat1"}, 64'(out_valid), 64'(0));
    tick();
    check({tag, "_lat2"}, 64'(out_valid), 64'(0));
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_data"}, 64'(out_data), 64'(exp));
    $display("%s: in_i=0x%06h in_q=0x%06h out_data=0x%08h", tag, i, q, out_data);
    pop_one();
  endtask

  initial begin
    logic [31:0] exp_word;
    int idx;
    int cyc;

    rst = 1'b1; run = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    in_i = '0; in_q = '0; in_stb = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_count", 64'(sample_count), 64'(0));
    rst = 1'b0;
    tick();
    run = 1'b1;
    tick();

    single("unity", 24'h000100, 24'hFFFF00, 32'h0001FFFF);
    single("round_tie", 24'h000080, 24'hFFFF80, 32'h0001FFFF);
    single("round_below", 24'h00007F, 24'hFFFF81, 32'h00000000);

    set_wr(1, 32'h1);
    single("swap", 24'h000100, 24'h000200, 32'h00020001);

    // Half mode: one packed word after the second sample of the pair
    set_wr(1, 32'h2);
    strobe(24'h010000, 24'h020000);
    repeat (4) tick();
    check("half_first_novalid", 64'(out_valid), 64'(0));
    strobe(24'h010000, 24'h020000);
    repeat (3) tick();
    check("half_valid", 64'(out_valid), 64'(1));
    check("half_data", 64'(out_data), 64'h01020102);
    $display("half pair: out_data=0x%08h", out_data);
    pop_one();
    tick();
    check("half_one_word", 64'(out_valid), 64'(0));

    // FIFO fill with 17 samples, overflow, clear, drain
    set_wr(1, 32'h0);
    restart();
    for (int k = 0; k < 17; k++) strobe(24'((k + 1) << 8), 24'((k + 16) << 8));
    repeat (5) tick();
    check("full_ovf", 64'(overflow), 64'(1));
    check("full_count", 64'(sample_count), 64'(17));
    check("full_valid", 64'(out_valid), 64'(1));
    set_wr(2, 32'h0);
    check("ovf_clear", 64'(overflow), 64'(0));
    out_ready = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 64) begin
      if (out_valid) begin
        exp_word = {16'(idx + 1), 16'(idx + 16)};
        check("drain_word", 64'(out_data), 64'(exp_word));
        $display("drain %0d: out_data=0x%08h", idx, out_data);
        idx++;
      end
      tick();
      cyc++;
    end
    check("drain_words", 64'(idx), 64'(16));
    tick();
    check("drain_empty", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // Half pair interrupted by run low must be discarded
    set_wr(1, 32'h2);
    restart();
    strobe(24'h010000, 24'h020000);
    repeat (4) tick();
    run = 1'b0;
    tick();
    tick();
    run = 1'b1;
    tick();
    strobe(24'h010000, 24'h020000);
    repeat (6) tick();
    check("mid_no_word", 64'(out_valid), 64'(0));
    check("mid_count", 64'(sample_count), 64'(1));

    // Saturation at 2x gain
    set_wr(1, 32'h0);
    set_wr(0, 32'h80008000);
    single("saturate", 24'h7FFFFF, 24'h800000, 32'h7FFF8000);

    // Asynchronous reset mid-operation
    strobe(24'h000100, 24'h000100);
    repeat (4) tick();
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_data", 64'(out_data), 64'(0));
    check("arst_ovf", 64'(overflow), 64'(0));
    check("arst_count", 64'(sample_count), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    single("post_rst_unity", 24'h000100, 24'hFFFF00, 32'h0001FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
